// File: rtl/cva5_types.sv
// cva5_types: retire trace record, FIFO entry and frame constants; CVA5_TRACE_INSTRUCTION_EN adds the instruction field
package cva5_types;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;
  } trace_retire_outputs_t;
`ifdef CVA5_TRACE_INSTRUCTION_EN
  typedef struct packed {
    logic        drop;
    logic [31:0] pc;
    logic [31:0] instruction;
  } trace_frame_entry_t;
  localparam int TRACE_FRAME_BYTES = 9;
`else
  typedef struct packed {
    logic        drop;
    logic [31:0] pc;
  } trace_frame_entry_t;
  localparam int TRACE_FRAME_BYTES = 5;
`endif
  localparam logic [7:0] TRACE_HEADER_MARKER = 8'h80;
endpackage

// File: rtl/trace_record_fifo.sv
// trace_record_fifo: synchronous FIFO with full/empty/count and async active-low reset
module trace_record_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  always_comb begin
    full = count == CW'(DEPTH);
    empty = count == '0;
    wr = wr_en && !full;
    rd = rd_en && !empty;
    rd_data = mem[rd_ptr];
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/trace_retire_serializer.sv
// trace_retire_serializer: buffers retire records and streams them as byte framed packets (CVA5_TRACE_INSTRUCTION_EN adds the instruction word)
module trace_retire_serializer
  import cva5_types::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  trace_retire_outputs_t retire,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [15:0]           dropped_count,
  output logic                  busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = TRACE_FRAME_BYTES * 8;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  trace_frame_entry_t head, frame, wr_entry;
  logic [5:0] seq, frame_seq;
  logic [3:0] byte_idx;
  logic drop_pending, full, empty, push, drop, last, accept, load;
  logic [CW-1:0] count;
  logic [FW-1:0] frame_bits;
  trace_record_fifo #(.WIDTH($bits(trace_frame_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(push),
    .wr_data(wr_entry),
    .rd_en(load),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    wr_entry = '0;
    wr_entry.drop = drop_pending;
    wr_entry.pc = retire.pc;
`ifdef CVA5_TRACE_INSTRUCTION_EN
    wr_entry.instruction = retire.instruction;
    frame_bits = {frame.instruction, frame.pc, TRACE_HEADER_MARKER | {1'b0, frame.drop, frame_seq}};
`else
    frame_bits = {frame.pc, TRACE_HEADER_MARKER | {1'b0, frame.drop, frame_seq}};
`endif
    push = retire.valid && !full;
    drop = retire.valid && full;
    last = byte_idx == 4'(TRACE_FRAME_BYTES - 1);
    accept = state == SEND && tx_ready;
    // the next frame is loaded on the same edge the last byte goes, so frames run back to back
    load = !empty && (state == IDLE || (accept && last));
    state_n = load ? SEND : (accept && last) ? IDLE : state;
    tx_valid = state == SEND;
    tx_data = tx_valid ? 8'(frame_bits >> {byte_idx, 3'b000}) : 8'h00;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      frame <= '0;
      frame_seq <= '0;
      byte_idx <= '0;
      seq <= '0;
      drop_pending <= 1'b0;
      dropped_count <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      busy <= push || (|count) || state_n == SEND;
      if (load) begin
        frame <= head;
        frame_seq <= seq;
        seq <= seq + 6'd1;
        byte_idx <= '0;
      end else if (accept) byte_idx <= byte_idx + 4'd1;
      if (push) drop_pending <= 1'b0;
      else if (drop) drop_pending <= 1'b1;
      if (drop && dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
    end
endmodule
